// File: rtl/fft_out_serializer_if.sv
// ---------------------------------------------------------------------------
// fft_out_serializer_if
//
// Connects the FFT output serializer to its environment. One bundle carries
// the parallel result bus coming from the FFT core and the serial sample
// stream going to downstream consumers.
//
// Signals:
//   valid_in    block strobe from the FFT core (one block = LANES samples)
//   din_i/din_q LANES packed signed samples, lane k at [(k+1)*DW-1 : k*DW]
//   dout_i/q    serial complex sample, signed
//   valid_out   dout_* carry a sample
//   ready_in    consumer accepts the sample when high with valid_out
//   dout_idx    bin index of the sample on dout_*, 0..NPT-1
//   frame_last  high with the final sample of a frame
//   overflow    sticky: at least one frame was dropped
//
// Modports:
//   master : environment side (drives blocks and ready_in, observes stream)
//   slave  : serializer side
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface fft_out_serializer_if #(
    parameter int LANES = 16,
    parameter int DW    = 13,
    parameter int NPT   = 512
);
    localparam int IDXW = $clog2(NPT);

    logic                    valid_in;
    logic [LANES*DW-1:0]     din_i;
    logic [LANES*DW-1:0]     din_q;

    logic signed [DW-1:0]    dout_i;
    logic signed [DW-1:0]    dout_q;
    logic                    valid_out;
    logic                    ready_in;
    logic [IDXW-1:0]         dout_idx;
    logic                    frame_last;
    logic                    overflow;

    modport master (
        output valid_in, din_i, din_q, ready_in,
        input  dout_i, dout_q, valid_out, dout_idx, frame_last, overflow
    );

    modport slave (
        input  valid_in, din_i, din_q, ready_in,
        output dout_i, dout_q, valid_out, dout_idx, frame_last, overflow
    );
endinterface

// File: rtl/fft_out_serializer.sv
// ---------------------------------------------------------------------------
// fft_out_serializer
//
// Receives FFT result frames as NBLK consecutive blocks of LANES complex
// samples, buffers each frame in one half of a ping-pong frame store, and
// streams it out one complex sample per cycle under valid/ready.
//
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset; discards all buffered frames
//   bus   fft_out_serializer_if.slave (block input, serial output, overflow)
//
// Write side: a frame starts on the first valid_in with wr_blk==0. If the
// target bank is not EMPTY at that moment the whole frame is discarded and
// the sticky overflow flag is raised. Gaps between blocks are allowed.
//
// Read side: valid_out follows the FULL state of the bank being read. The
// output sample is selected combinationally from the store; a bank returns
// to EMPTY on the handshake of its last sample.
//
// Optional build macro:
//   FFT_OUT_BITREV_EN  output sample k is read from store position
//                      bitrev(k), turning bit-reversed FFT order into
//                      natural bin order. dout_idx still reports k.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module fft_out_serializer #(
    parameter int LANES = 16,
    parameter int DW    = 13,
    parameter int NPT   = 512
) (
    input  logic                 clk,
    input  logic                 rstn,
    fft_out_serializer_if.slave  bus
);

    localparam int NBLK  = NPT / LANES;
    localparam int BLKW  = $clog2(NBLK);
    localparam int LANEW = $clog2(LANES);
    localparam int IDXW  = $clog2(NPT);
    localparam int WORDW = LANES * DW;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    bank_state_e      bank_q [2];
    bank_state_e      bank_d [2];
    logic             wr_bank_q,  wr_bank_d;
    logic [BLKW-1:0]  wr_blk_q,   wr_blk_d;
    logic             rd_bank_q,  rd_bank_d;
    logic [IDXW-1:0]  rd_idx_q,   rd_idx_d;
    logic             drop_q,     drop_d;
    logic             overflow_q, overflow_d;

    // Frame store: one word per block, both banks.
    logic [WORDW-1:0] store_re_q [2][NBLK];
    logic [WORDW-1:0] store_im_q [2][NBLK];

    // Combinational helpers
    logic             store_we;
    logic             blk_drop;
    logic             rd_valid;
    logic             rd_hs;
    logic [IDXW-1:0]  rd_pos;
    logic [BLKW-1:0]  rd_blk;
    logic [LANEW-1:0] rd_lane;
    logic [WORDW-1:0] rd_word_re;
    logic [WORDW-1:0] rd_word_im;
    logic [DW-1:0]    rd_samp_re;
    logic [DW-1:0]    rd_samp_im;

`ifdef FFT_OUT_BITREV_EN
    function automatic logic [IDXW-1:0] bitrev(input logic [IDXW-1:0] a);
        logic [IDXW-1:0] r;
        for (int b = 0; b < IDXW; b++) begin
            r[b] = a[IDXW-1-b];
        end
        return r;
    endfunction
`endif

    assign rd_valid = (bank_q[rd_bank_q] == BANK_FULL);
    assign rd_hs    = rd_valid && bus.ready_in;

    // -----------------------------------------------------------------------
    // Next-state logic for both sides of the ping-pong store
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here receives a default first, so no
        // path through the block leaves a value held and no latch is inferred.
        bank_d     = bank_q;
        wr_bank_d  = wr_bank_q;
        wr_blk_d   = wr_blk_q;
        rd_bank_d  = rd_bank_q;
        rd_idx_d   = rd_idx_q;
        drop_d     = drop_q;
        overflow_d = overflow_q;
        store_we   = 1'b0;
        blk_drop   = drop_q;

        // Write side. The admission decision for a new frame uses the bank
        // state before this edge, so a bank that finishes draining in the
        // same cycle still counts as occupied.
        if (bus.valid_in) begin
            if (wr_blk_q == '0) begin
                blk_drop = (bank_q[wr_bank_q] != BANK_EMPTY);
                drop_d   = blk_drop;
                if (blk_drop) begin
                    overflow_d = 1'b1;
                end else begin
                    bank_d[wr_bank_q] = BANK_FILLING;
                end
            end

            store_we = !blk_drop;

            if (wr_blk_q == BLKW'(NBLK - 1)) begin
                wr_blk_d = '0;
                drop_d   = 1'b0;
                if (!blk_drop) begin
                    bank_d[wr_bank_q] = BANK_FULL;
                    wr_bank_d         = ~wr_bank_q;
                end
            end else begin
                wr_blk_d = wr_blk_q + 1'b1;
            end
        end

        // Read side. A bank being read is FULL, while the write side only
        // moves banks that are EMPTY or FILLING, so the two updates never
        // touch the same bank in one cycle.
        if (rd_hs) begin
            if (rd_idx_q == IDXW'(NPT - 1)) begin
                rd_idx_d          = '0;
                bank_d[rd_bank_q] = BANK_EMPTY;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                rd_idx_d = rd_idx_q + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_q[0]  <= BANK_EMPTY;
            bank_q[1]  <= BANK_EMPTY;
            wr_bank_q  <= 1'b0;
            wr_blk_q   <= '0;
            rd_bank_q  <= 1'b0;
            rd_idx_q   <= '0;
            drop_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            bank_q     <= bank_d;
            wr_bank_q  <= wr_bank_d;
            wr_blk_q   <= wr_blk_d;
            rd_bank_q  <= rd_bank_d;
            rd_idx_q   <= rd_idx_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
        end
    end

    // -----------------------------------------------------------------------
    // Frame store
    // -----------------------------------------------------------------------
    // NOTE: the store carries no reset. Its contents are only ever observed
    // through a FULL bank, and the bank states are reset, so stale data can
    // never reach the outputs; leaving it out keeps the reset tree small.
    always_ff @(posedge clk) begin
        if (store_we) begin
            store_re_q[wr_bank_q][wr_blk_q] <= bus.din_i;
            store_im_q[wr_bank_q][wr_blk_q] <= bus.din_q;
        end
    end

    // -----------------------------------------------------------------------
    // Read mux: sample position -> block word -> lane slice
    // -----------------------------------------------------------------------
    always_comb begin
`ifdef FFT_OUT_BITREV_EN
        rd_pos = bitrev(rd_idx_q);
`else
        rd_pos = rd_idx_q;
`endif
        rd_blk     = rd_pos[IDXW-1:LANEW];
        rd_lane    = rd_pos[LANEW-1:0];
        rd_word_re = store_re_q[rd_bank_q][rd_blk];
        rd_word_im = store_im_q[rd_bank_q][rd_blk];
        rd_samp_re = rd_word_re[int'(rd_lane) * DW +: DW];
        rd_samp_im = rd_word_im[int'(rd_lane) * DW +: DW];
    end

    // Outputs are forced to zero whenever no sample is presented.
    assign bus.valid_out  = rd_valid;
    assign bus.dout_i     = rd_valid ? rd_samp_re : '0;
    assign bus.dout_q     = rd_valid ? rd_samp_im : '0;
    assign bus.dout_idx   = rd_valid ? rd_idx_q : '0;
    assign bus.frame_last = rd_valid && (rd_idx_q == IDXW'(NPT - 1));
    assign bus.overflow   = overflow_q;

endmodule
